dso_trig_capture: RTL and testbench
===================================

// Module: dso_trig_capture
// PURPOSE
//  Multi-channel triggered waveform capture for the DSO: stores NCH decimated AD channels in a
//  circular buffer, detects an edge trigger with hysteresis on a selectable channel, and freezes a
//  DEPTH-sample frame with programmable pre-trigger length. Sits between the decimator and the
//  waveform renderer; supports normal/auto/single modes. Single clock domain, readout included.
// PARAMETERS
//  DW      8      sample width (bits)
//  AW      10     buffer address width; DEPTH = 2**AW samples per channel
//  NCH     2      channel count; localparam CW = (NCH>1) ? $clog2(NCH) : 1
//  AUTO_TO 65535  valid samples spent in ARMED before an auto-mode forced trigger
// PORTS
//  ad_clk     in   1       sample/system clock
//  rst        in   1       asynchronous, active-high reset
//  ad_data    in   NCH*DW  channel c at [c*DW +: DW]
//  deci_valid in   1       sample strobe; only valid cycles write/count/detect
//  wave_run   in   1       1 = acquire, 0 = stop/hold
//  single     in   1       single-shot mode
//  auto_mode  in   1       force trigger after AUTO_TO samples in ARMED
//  trig_ch    in   CW      trigger source channel (>= NCH treated as 0)
//  trig_level in   DW      trigger level
//  trig_hyst  in   DW      hysteresis band
//  trig_edge  in   2       00 rising, 01 falling, 1x either
//  pre_len    in   AW      pre-trigger samples (0..DEPTH-1)
//  rd_over    in   1       renderer finished reading frame
//  rd_ch      in   CW      readout channel
//  rd_addr    in   AW      frame-relative address, 0 = oldest sample of frame
//  rd_data    out  DW      frame sample, 1-cycle latency
//  capt_done  out  1       frame complete and frozen
//  trig_auto  out  1       current/last frame was auto-triggered
//  trig_ptr   out  AW      absolute buffer address of trigger sample
//  state      out  3       FSM state code
// BEHAVIOUR
//  - Reset: state=IDLE(0), capt_done=0, trig_auto=0, trig_ptr=0, rd_data=0, wr_ptr=0, counters=0,
//    hysteresis arm=0, single_lock=0. Buffer contents not reset.
//  - trig_ch/level/hyst/edge and pre_len latched on IDLE->PRE; frame uses latched values only.
//  - Write: in PRE/ARMED/POST on deci_valid, all channels written at wr_ptr, wr_ptr+1 mod DEPTH.
//  - FSM: IDLE(0) -> PRE when wave_run & !single_lock; cnt=0.
//    PRE(1): cnt++ per written sample; -> ARMED when cnt==pre_len (pre_len=0: next cycle).
//    ARMED(2): clear arm and timeout on entry. On valid sample matching trigger: trig_ptr=wr_ptr
//    (that sample's address), trig_auto=0 -> POST. If auto_mode & timeout==AUTO_TO-1 on a valid
//    sample with no trigger: forced trigger, trig_auto=1.
//    POST(3): after DEPTH-1-pre_len further samples written -> DONE (zero: directly next cycle).
//    DONE(4): no writes, capt_done=1. rd_over & wave_run: single=1 -> IDLE, single_lock=1;
//    else -> PRE (capt_done=0). wave_run=0 in DONE: frame held, rd_over ignored.
//  - wave_run=0 in PRE/ARMED/POST aborts -> IDLE next cycle, capt_done=0. single_lock clears while
//    wave_run=0.
//  - Hysteresis (sample s on latched channel, valid cycles in ARMED): rising arm set when
//    s < level-hyst (saturate 0), trigger when armed & s >= level. Falling arm set when
//    s > level+hyst (saturate 2**DW-1), trigger when armed & s <= level. Either: both paths,
//    first to fire wins. Trigger sample itself need not arm.
//  - Readout: rd_data <= mem[rd_ch][(trig_ptr - pre_len + rd_addr) mod DEPTH], AW-bit wrap,
//    registered, 1 cycle; valid any state, meaningful when capt_done=1. rd_ch >= NCH returns 0.
//  - Simultaneous rd_over and wave_run fall in DONE: wave_run wins (hold).
// TESTING (bench config AW=4, NCH=2, AUTO_TO=32, deci_valid=1 unless stated)
//  1 ramp 0,1,2.. on ch0, rising, level 100, hyst 4, pre_len 4 -> trigger on 100, capt_done
//    after 11 post samples; rd_addr 0->96, 4->100, 15->111 (1-cycle latency).
//  2 ch1 alternates 98/102, trig_ch 1, level 100, hyst 4, auto 0 -> stays ARMED, capt_done=0;
//    then one 90 followed by 101 -> triggers on 101.
//  3 flat 50, auto_mode 1 -> forced trigger after 32 ARMED samples, trig_auto=1, frame captured.
//  4 single=1: DONE + rd_over -> IDLE, held with wave_run=1; wave_run 0->1 -> new capture.
//  5 wave_run dropped in POST -> IDLE next cycle, capt_done=0; rst mid-ARMED -> all outputs 0.
//  6 pre_len 0 -> rd_addr 0 returns trigger sample; pre_len 15 after wr_ptr wrap -> rd_addr 15 =
//    trigger sample; deci_valid every 3rd cycle gives identical frame.

Source files
------------

// File: rtl/dso_trig_capture.sv
// Triggered multi-channel waveform capture: circular sample buffer, hysteresis edge trigger,
// pre-trigger framing, normal/auto/single acquisition and registered frame readout.
module dso_trig_capture #(
   parameter int unsigned DW      = 8,
   parameter int unsigned AW      = 10,
   parameter int unsigned NCH     = 2,
   parameter int unsigned AUTO_TO = 65535,
   localparam int unsigned CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              ad_clk,
   input  logic              rst,
   input  logic [NCH*DW-1:0] ad_data,
   input  logic              deci_valid,
   input  logic              wave_run,
   input  logic              single,
   input  logic              auto_mode,
   input  logic [CW-1:0]     trig_ch,
   input  logic [DW-1:0]     trig_level,
   input  logic [DW-1:0]     trig_hyst,
   input  logic [1:0]        trig_edge,
   input  logic [AW-1:0]     pre_len,
   input  logic              rd_over,
   input  logic [CW-1:0]     rd_ch,
   input  logic [AW-1:0]     rd_addr,
   output logic [DW-1:0]     rd_data,
   output logic              capt_done,
   output logic              trig_auto,
   output logic [AW-1:0]     trig_ptr,
   output logic [2:0]        state
);

   localparam int unsigned DEPTH = 2**AW;
   localparam int unsigned TW    = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(AUTO_TO - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_ARMED = 3'd2,
      S_POST  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, cnt_q, cnt_d, trig_ptr_q, trig_ptr_d, pre_q, pre_d;
   logic [TW-1:0] to_q, to_d;
   logic          arm_r_q, arm_r_d, arm_f_q, arm_f_d;
   logic          lock_q, lock_d, auto_q, auto_d;
   logic [CW-1:0] ch_q, ch_d;
   logic [DW-1:0] lvl_q, lvl_d, hyst_q, hyst_d, rd_data_q, rd_data_d;
   logic [1:0]    edge_q, edge_d;

   logic [DW-1:0]     smp, lo, hi;
   logic [DW:0]       hi_sum;
   logic              hit_r, hit_f, hit, wr_en;
   logic [AW-1:0]     post_last, rd_idx;
   logic [NCH*DW-1:0] rd_all;

   // One buffer per channel, sharing the write pointer and frame read index.
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [DW-1:0] mem [DEPTH];
      always_ff @(posedge ad_clk) begin
         if (wr_en) mem[wr_ptr_q] <= ad_data[c*DW +: DW];
      end
      assign rd_all[c*DW +: DW] = mem[rd_idx];
   end

   always_ff @(posedge ad_clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         cnt_q      <= '0;
         trig_ptr_q <= '0;
         pre_q      <= '0;
         to_q       <= '0;
         arm_r_q    <= 1'b0;
         arm_f_q    <= 1'b0;
         lock_q     <= 1'b0;
         auto_q     <= 1'b0;
         ch_q       <= '0;
         lvl_q      <= '0;
         hyst_q     <= '0;
         edge_q     <= '0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         cnt_q      <= cnt_d;
         trig_ptr_q <= trig_ptr_d;
         pre_q      <= pre_d;
         to_q       <= to_d;
         arm_r_q    <= arm_r_d;
         arm_f_q    <= arm_f_d;
         lock_q     <= lock_d;
         auto_q     <= auto_d;
         ch_q       <= ch_d;
         lvl_q      <= lvl_d;
         hyst_q     <= hyst_d;
         edge_q     <= edge_d;
         rd_data_q  <= rd_data_d;
      end
   end

   always_comb begin
      smp = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         if (c == 32'(ch_q)) smp = ad_data[c*DW +: DW];
      end
      lo     = (lvl_q > hyst_q) ? lvl_q - hyst_q : '0;
      hi_sum = {1'b0, lvl_q} + {1'b0, hyst_q};
      hi     = hi_sum[DW] ? '1 : hi_sum[DW-1:0];
      hit_r  = (edge_q[1] || !edge_q[0]) && arm_r_q && (smp >= lvl_q);
      hit_f  = (edge_q[1] ||  edge_q[0]) && arm_f_q && (smp <= lvl_q);
      hit    = hit_r || hit_f;

      // DEPTH-1-pre_len; the last POST slot is never written so the oldest frame sample survives.
      post_last = ~pre_q;
      wr_en     = deci_valid && ((state_q == S_PRE) || (state_q == S_ARMED) ||
                                 ((state_q == S_POST) && (cnt_q != post_last)));
      wr_ptr_d  = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;

      state_d    = state_q;
      cnt_d      = cnt_q;
      trig_ptr_d = trig_ptr_q;
      pre_d      = pre_q;
      to_d       = to_q;
      arm_r_d    = arm_r_q;
      arm_f_d    = arm_f_q;
      lock_d     = lock_q;
      auto_d     = auto_q;
      ch_d       = ch_q;
      lvl_d      = lvl_q;
      hyst_d     = hyst_q;
      edge_d     = edge_q;

      case (state_q)
         S_IDLE: begin
            if (wave_run && !lock_q) begin
               state_d = S_PRE;
               cnt_d   = '0;
               ch_d    = (32'(trig_ch) < NCH) ? trig_ch : '0;
               lvl_d   = trig_level;
               hyst_d  = trig_hyst;
               edge_d  = trig_edge;
               pre_d   = pre_len;
            end
         end
         S_PRE: begin
            if (!wave_run) begin
               state_d = S_IDLE;
            end else if (cnt_q == pre_q) begin
               state_d = S_ARMED;
            end else if (deci_valid) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == pre_q) state_d = S_ARMED;
            end
            if (state_d == S_ARMED) begin
               arm_r_d = 1'b0;
               arm_f_d = 1'b0;
               to_d    = '0;
            end
         end
         S_ARMED: begin
            if (!wave_run) begin
               state_d = S_IDLE;
            end else if (deci_valid) begin
               if (hit || (auto_mode && (to_q == TO_LAST))) begin
                  state_d    = S_POST;
                  cnt_d      = '0;
                  trig_ptr_d = wr_ptr_q;
                  auto_d     = !hit;
               end else begin
                  if (to_q != TO_LAST) to_d = to_q + 1'b1;
                  arm_r_d = arm_r_q || (smp < lo);
                  arm_f_d = arm_f_q || (smp > hi);
               end
            end
         end
         S_POST: begin
            if (!wave_run) begin
               state_d = S_IDLE;
            end else if (cnt_q == post_last) begin
               state_d = S_DONE;
            end else if (deci_valid) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == post_last) state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (wave_run && rd_over) begin
               if (single) begin
                  state_d = S_IDLE;
                  lock_d  = 1'b1;
               end else begin
                  state_d = S_PRE;
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (!wave_run) lock_d = 1'b0;

      rd_idx    = trig_ptr_q - pre_q + rd_addr;
      rd_data_d = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         if (c == 32'(rd_ch)) rd_data_d = rd_all[c*DW +: DW];
      end
   end

   always_comb begin
      state     = state_q;
      capt_done = (state_q == S_DONE);
      trig_auto = auto_q;
      trig_ptr  = trig_ptr_q;
      rd_data   = rd_data_q;
   end

endmodule

// File: tb/tb_dso_trig_capture.sv
// Directed self-checking bench for dso_trig_capture (AW=4, NCH=2, AUTO_TO=32).
module tb_dso_trig_capture;

   logic        ad_clk = 1'b0;
   logic        rst;
   logic [15:0] ad_data;
   logic        deci_valid, wave_run, single, auto_mode, rd_over;
   logic        trig_ch, rd_ch;
   logic [7:0]  trig_level, trig_hyst, rd_data;
   logic [1:0]  trig_edge;
   logic [3:0]  pre_len, rd_addr, trig_ptr;
   logic        capt_done, trig_auto;
   logic [2:0]  state;

   int n_checks = 0;
   int n_errors = 0;

   dso_trig_capture #(.DW(8), .AW(4), .NCH(2), .AUTO_TO(32)) dut (
      .ad_clk(ad_clk), .rst(rst), .ad_data(ad_data), .deci_valid(deci_valid),
      .wave_run(wave_run), .single(single), .auto_mode(auto_mode), .trig_ch(trig_ch),
      .trig_level(trig_level), .trig_hyst(trig_hyst), .trig_edge(trig_edge),
      .pre_len(pre_len), .rd_over(rd_over), .rd_ch(rd_ch), .rd_addr(rd_addr),
      .rd_data(rd_data), .capt_done(capt_done), .trig_auto(trig_auto),
      .trig_ptr(trig_ptr), .state(state)
   );

   always #5 ad_clk = ~ad_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic [7:0] a0, input logic [7:0] a1, input logic v);
      ad_data    = {a1, a0};
      deci_valid = v;
      @(posedge ad_clk);
      #1;
   endtask

   task automatic rd(input logic ch, input logic [3:0] a, input logic [7:0] exp, input string tag);
      rd_ch   = ch;
      rd_addr = a;
      step(8'd0, 8'd0, 1'b0);
      check(tag, rd_data, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ad_data = '0; deci_valid = 1'b0; wave_run = 1'b0; single = 1'b0; auto_mode = 1'b0;
      rd_over = 1'b0; trig_ch = 1'b0; rd_ch = 1'b0; rd_addr = '0;
      trig_level = 8'd100; trig_hyst = 8'd4; trig_edge = 2'b00; pre_len = 4'd4;
      repeat (2) @(posedge ad_clk);
      #1;
      rst = 1'b0;
   endtask

   // Ramp v on ch0 (255-v on ch1), each valid sample followed by 'gap' invalid garbage cycles.
   task automatic run_ramp(input int gap, input string pfx);
      wave_run = 1'b1;
      step(8'd0, 8'd255, 1'b1);
      for (int v = 1; v <= 110; v++) begin
         step(8'(v), 8'(255 - v), 1'b1);
         repeat (gap) step(8'd255, 8'd0, 1'b0);
      end
      check({pfx, "_post_state"}, state, 3);
      check({pfx, "_not_done"}, capt_done, 0);
      step(8'd111, 8'd144, 1'b1);
      repeat (gap) step(8'd255, 8'd0, 1'b0);
      check({pfx, "_done_state"}, state, 4);
      check({pfx, "_capt_done"}, capt_done, 1);
      check({pfx, "_trig_ptr"}, trig_ptr, 3);
      check({pfx, "_trig_auto"}, trig_auto, 0);
      rd(1'b0, 4'd0, 8'd96, {pfx, "_rd0"});
      rd_addr = 4'd4;
      #2;
      check({pfx, "_rd_latency"}, rd_data, 96);
      step(8'd0, 8'd0, 1'b0);
      check({pfx, "_rd4"}, rd_data, 100);
      rd(1'b0, 4'd15, 8'd111, {pfx, "_rd15"});
      rd(1'b1, 4'd0, 8'd159, {pfx, "_rd_ch1"});
   endtask

   initial begin
      // Reset state and ramp capture
      do_reset();
      check("rst_state", state, 0);
      check("rst_capt_done", capt_done, 0);
      check("rst_trig_ptr", trig_ptr, 0);
      check("rst_trig_auto", trig_auto, 0);
      check("rst_rd_data", rd_data, 0);
      run_ramp(0, "ramp");

      wave_run = 1'b0; rd_over = 1'b1;
      step(8'd0, 8'd0, 1'b1);
      check("done_hold_state", state, 4);
      check("done_hold_capt", capt_done, 1);
      wave_run = 1'b1;
      step(8'd0, 8'd0, 1'b1);
      check("rearm_state", state, 1);
      check("rearm_capt", capt_done, 0);
      rd_over = 1'b0;

      // Hysteresis on ch1: 98/102 never arms, 90 arms, 101 fires
      do_reset();
      trig_ch = 1'b1; wave_run = 1'b1;
      step(8'd0, 8'd98, 1'b1);
      for (int i = 0; i < 44; i++)
         step((i % 2) ? 8'd200 : 8'd0, (i % 2) ? 8'd102 : 8'd98, 1'b1);
      check("hyst_still_armed", state, 2);
      check("hyst_no_done", capt_done, 0);
      step(8'd0, 8'd90, 1'b1);
      check("hyst_arm_only", state, 2);
      step(8'd0, 8'd101, 1'b1);
      check("hyst_trig_state", state, 3);
      check("hyst_trig_ptr", trig_ptr, 13);
      repeat (11) step(8'd0, 8'd50, 1'b1);
      check("hyst_capt_done", capt_done, 1);
      rd(1'b1, 4'd4, 8'd101, "hyst_rd_trig");
      rd(1'b1, 4'd3, 8'd90, "hyst_rd_pre");

      // Auto-mode forced trigger on flat input
      do_reset();
      auto_mode = 1'b1; wave_run = 1'b1;
      step(8'd50, 8'd50, 1'b1);
      repeat (4) step(8'd50, 8'd50, 1'b1);
      check("auto_armed", state, 2);
      repeat (31) step(8'd50, 8'd50, 1'b1);
      check("auto_wait", state, 2);
      step(8'd50, 8'd50, 1'b1);
      check("auto_fire_state", state, 3);
      check("auto_trig_auto", trig_auto, 1);
      check("auto_trig_ptr", trig_ptr, 3);
      repeat (11) step(8'd50, 8'd50, 1'b1);
      check("auto_capt_done", capt_done, 1);
      check("auto_flag_kept", trig_auto, 1);

      // Single-shot lock
      single = 1'b1; rd_over = 1'b1;
      step(8'd0, 8'd0, 1'b1);
      check("single_idle", state, 0);
      check("single_capt_clr", capt_done, 0);
      rd_over = 1'b0;
      repeat (3) step(8'd0, 8'd0, 1'b1);
      check("single_locked", state, 0);
      wave_run = 1'b0;
      step(8'd0, 8'd0, 1'b1);
      wave_run = 1'b1;
      step(8'd0, 8'd0, 1'b1);
      check("single_relaunch", state, 1);
      single = 1'b0; auto_mode = 1'b0;

      // Abort in POST, then asynchronous reset in ARMED
      do_reset();
      wave_run = 1'b1;
      step(8'd0, 8'd0, 1'b1);
      repeat (5) step(8'd0, 8'd0, 1'b1);
      step(8'd120, 8'd0, 1'b1);
      check("abort_in_post", state, 3);
      check("abort_trig_ptr", trig_ptr, 5);
      wave_run = 1'b0;
      step(8'd0, 8'd0, 1'b1);
      check("abort_idle", state, 0);
      check("abort_capt", capt_done, 0);
      rd_ch = 1'b0; rd_addr = 4'd4; wave_run = 1'b1;
      repeat (7) step(8'd0, 8'd0, 1'b1);
      check("prerst_armed", state, 2);
      check("prerst_rd", rd_data, 120);
      rst = 1'b1;
      #1;
      check("arst_state", state, 0);
      check("arst_trig_ptr", trig_ptr, 0);
      check("arst_capt", capt_done, 0);
      check("arst_auto", trig_auto, 0);
      check("arst_rd_data", rd_data, 0);

      // pre_len = 0
      do_reset();
      pre_len = 4'd0; wave_run = 1'b1;
      step(8'd0, 8'd0, 1'b1);
      step(8'd10, 8'd0, 1'b1);
      check("pre0_armed", state, 2);
      step(8'd10, 8'd0, 1'b1);
      step(8'd100, 8'd0, 1'b1);
      check("pre0_trig_ptr", trig_ptr, 2);
      for (int k = 1; k <= 14; k++) step(8'(100 + k), 8'd0, 1'b1);
      check("pre0_post", state, 3);
      step(8'd115, 8'd0, 1'b1);
      check("pre0_done", capt_done, 1);
      rd(1'b0, 4'd0, 8'd100, "pre0_rd0");
      rd(1'b0, 4'd1, 8'd101, "pre0_rd1");
      rd(1'b0, 4'd15, 8'd115, "pre0_rd15");

      // pre_len = 15 after write-pointer wrap
      do_reset();
      pre_len = 4'd15; wave_run = 1'b1;
      step(8'd0, 8'd0, 1'b1);
      for (int v = 1; v <= 99; v++) step(8'(v), 8'd0, 1'b1);
      check("pre15_armed", state, 2);
      step(8'd100, 8'd0, 1'b1);
      check("pre15_trig_ptr", trig_ptr, 3);
      step(8'd101, 8'd0, 1'b1);
      check("pre15_done", state, 4);
      rd(1'b0, 4'd15, 8'd100, "pre15_rd15");
      rd(1'b0, 4'd14, 8'd99, "pre15_rd14");
      rd(1'b0, 4'd0, 8'd85, "pre15_rd0");

      // Sparse deci_valid must give the same frame
      do_reset();
      run_ramp(2, "sparse");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
